// File: rtl/uart_rom_loader_pkg.sv
// uart_rom_loader_pkg: shared defaults and state encodings for the UART ROM loader
package uart_rom_loader_pkg;
    localparam int DEF_CLK_DIV    = 434;
    localparam int DEF_ADDR_WIDTH = 12;
    typedef enum logic [1:0] {LD_LEN, LD_DATA, LD_DONE, LD_ERR} ld_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rom_loader_if.sv
// uart_rom_loader_if: inst_rom write port plus core reset and load status
interface uart_rom_loader_if import uart_rom_loader_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  rom_we_o;
    logic [ADDR_WIDTH-1:0] rom_addr_o;
    logic [31:0]           rom_wdata_o;
    logic                  core_rst_n_o;
    logic                  load_done_o;
    logic                  load_err_o;
    modport master(output rom_we_o, rom_addr_o, rom_wdata_o, core_rst_n_o, load_done_o, load_err_o);
    modport slave(input rom_we_o, rom_addr_o, rom_wdata_o, core_rst_n_o, load_done_o, load_err_o);
endinterface

// File: rtl/uart_rom_loader_rx.sv
// uart_rx: 8N1 receiver with input synchronizer, byte-valid and framing-error pulses
module uart_rx import uart_rom_loader_pkg::*; #(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] data
);
    localparam int CW = $clog2(CLK_DIV + 1);
    logic [2:0] sync;
    rx_state_t st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sh, sh_n;
    logic bv_n, fe_n, rxs, prev;
    assign rxs  = sync[1];
    assign prev = sync[2];
    assign data = sh;
    // sync[1:0] is the synchronizer, sync[2] remembers the previous synchronized level for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync       <= 3'b111;
            st         <= RX_IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[1:0], rxd};
            st         <= st_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            sh         <= sh_n;
            byte_valid <= bv_n;
            frame_err  <= fe_n;
        end
    end
    // bit timing: half a bit to the start-bit centre, then one full bit per sample
    always_comb begin
        st_n  = st;
        cnt_n = cnt + 1'b1;
        idx_n = idx;
        sh_n  = sh;
        bv_n  = 1'b0;
        fe_n  = 1'b0;
        case (st)
            RX_IDLE: begin
                cnt_n = '0;
                if (prev && !rxs) st_n = RX_START;
            end
            RX_START: if (cnt == CW'(CLK_DIV / 2 - 1)) begin
                cnt_n = '0;
                st_n  = rxs ? RX_IDLE : RX_BITS;
            end
            RX_BITS: if (cnt == CW'(CLK_DIV - 1)) begin
                cnt_n = '0;
                sh_n  = {rxs, sh[7:1]};
                idx_n = idx + 1'b1;
                if (idx == 3'd7) st_n = RX_STOP;
            end
            default: if (cnt == CW'(CLK_DIV - 1)) begin
                cnt_n = '0;
                st_n  = RX_IDLE;
                bv_n  = rxs;
                fe_n  = !rxs;
            end
        endcase
    end
endmodule

// File: rtl/uart_rom_loader.sv
// uart_rom_loader: receives a length-prefixed word image over UART and writes it into inst_rom
module uart_rom_loader import uart_rom_loader_pkg::*; #(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_rxd,
    uart_rom_loader_if.master bus
);
    localparam logic [32:0] MAX_N = 33'd1 << ADDR_WIDTH;
    logic byte_valid, frame_err, wr, last_byte;
    logic [7:0] rx_byte;
    ld_state_t state, state_n;
    logic [1:0] bcnt;
    logic [31:0] acc, word;
    logic [ADDR_WIDTH:0] n_words, wcnt;
    uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk(clk),
        .rst_n(rst_n),
        .rxd(uart_rxd),
        .byte_valid(byte_valid),
        .frame_err(frame_err),
        .data(rx_byte)
    );
    assign word      = {rx_byte, acc[31:8]};
    assign last_byte = byte_valid && bcnt == 2'd3;
    // loader state and write strobe; DONE/ERR are terminal so UART traffic there is ignored
    always_comb begin
        state_n = state;
        wr      = 1'b0;
        case (state)
            LD_LEN: begin
                if (frame_err) state_n = LD_ERR;
                else if (last_byte) state_n = word == '0 ? LD_DONE : {1'b0, word} > MAX_N ? LD_ERR : LD_DATA;
            end
            LD_DATA: begin
                if (frame_err) state_n = LD_ERR;
                else if (last_byte) begin
                    wr = 1'b1;
                    if (wcnt + 1'b1 == n_words) state_n = LD_DONE;
                end
            end
            default: ;
        endcase
    end
    // little-endian byte assembly, word count capture and registered ROM write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= LD_LEN;
            bcnt             <= '0;
            acc              <= '0;
            n_words          <= '0;
            wcnt             <= '0;
            bus.rom_we_o     <= 1'b0;
            bus.rom_addr_o   <= '0;
            bus.rom_wdata_o  <= '0;
            bus.core_rst_n_o <= 1'b0;
            bus.load_done_o  <= 1'b0;
            bus.load_err_o   <= 1'b0;
        end else begin
            state            <= state_n;
            bus.rom_we_o     <= wr;
            bus.load_done_o  <= state == LD_DONE;
            bus.core_rst_n_o <= state == LD_DONE;
            bus.load_err_o   <= state == LD_ERR;
            if (byte_valid && (state == LD_LEN || state == LD_DATA)) begin
                acc  <= word;
                bcnt <= bcnt + 1'b1;
            end
            if (state == LD_LEN && last_byte) n_words <= word[ADDR_WIDTH:0];
            if (wr) begin
                bus.rom_addr_o  <= wcnt[ADDR_WIDTH-1:0];
                bus.rom_wdata_o <= word;
                wcnt            <= wcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: table-driven and randomized image loads checked against a byte-stream model
module tb_uart_rom_loader;
    localparam int CD = 16;
    localparam int AW = 12;
    typedef struct {
        logic [31:0] n;
        int          nw;
        int          bad;
        bit          fixed;
        logic        ed;
        logic        ee;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cyc = -1;
    logic [43:0] got_wr[$];
    int we_cyc[$];
    int bv_cyc[$];
    logic [43:0] exp_wr[$];
    logic exp_done, exp_err;
    logic [7:0] tx[$];
    vec_t vecs[11];
    always #5 clk = ~clk;
    uart_rom_loader_if #(.ADDR_WIDTH(AW)) bus();
    uart_rom_loader #(.CLK_DIV(CD), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_rxd(rxd),
        .bus(bus)
    );
    // observe writes, byte arrivals and the done rise on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (bus.rom_we_o) begin
            got_wr.push_back({bus.rom_addr_o, bus.rom_wdata_o});
            we_cyc.push_back(cyc);
        end
        if (dut.byte_valid) bv_cyc.push_back(cyc);
        if (bus.load_done_o && done_cyc < 0) done_cyc = cyc;
    end
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CD) @(negedge clk);
        end
        rxd = stop;
        repeat (CD) @(negedge clk);
        rxd = 1'b1;
        repeat (CD) @(negedge clk);
    endtask
    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check({nm, "/rst_we"}, 64'(bus.rom_we_o), 64'd0);
        check({nm, "/rst_addr"}, 64'(bus.rom_addr_o), 64'd0);
        check({nm, "/rst_wdata"}, 64'(bus.rom_wdata_o), 64'd0);
        check({nm, "/rst_core"}, 64'(bus.core_rst_n_o), 64'd0);
        check({nm, "/rst_done"}, 64'(bus.load_done_o), 64'd0);
        check({nm, "/rst_err"}, 64'(bus.load_err_o), 64'd0);
        @(posedge clk);
        got_wr.delete();
        we_cyc.delete();
        bv_cyc.delete();
        done_cyc = -1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask
    task automatic make_image(input logic [31:0] n, input int nw, input bit fixed);
        logic [31:0] w;
        tx.delete();
        for (int k = 0; k < 4; k++) tx.push_back(n[8*k +: 8]);
        for (int i = 0; i < nw; i++) begin
            w = fixed ? (i == 0 ? 32'h0000_0413 : 32'h0010_0093) : $urandom;
            for (int k = 0; k < 4; k++) tx.push_back(w[8*k +: 8]);
        end
    endtask
    // byte-stream semantics: count word, then N words; a bad stop bit anywhere before completion aborts
    task automatic model(input int bad);
        logic [31:0] n;
        exp_wr.delete();
        exp_done = 1'b0;
        exp_err = 1'b0;
        if (bad >= 0 && bad < 4) begin
            exp_err = 1'b1;
            return;
        end
        if (tx.size() < 4) return;
        n = {tx[3], tx[2], tx[1], tx[0]};
        if (n == 0) begin
            exp_done = 1'b1;
            return;
        end
        if (n > (32'd1 << AW)) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            if (bad >= 4 + 4 * i && bad < 8 + 4 * i) begin
                exp_err = 1'b1;
                return;
            end
            if (tx.size() < 8 + 4 * i) return;
            exp_wr.push_back({12'(i), tx[7+4*i], tx[6+4*i], tx[5+4*i], tx[4+4*i]});
        end
        exp_done = 1'b1;
    endtask
    task automatic send_all(input int bad);
        for (int i = 0; i < tx.size(); i++) send_byte(tx[i], i != bad);
    endtask
    task automatic verify(input string nm, input logic ed, input logic ee);
        repeat (40) @(negedge clk);
        check({nm, "/nwrites"}, 64'(got_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check($sformatf("%s/write%0d", nm, i), 64'(got_wr[i]), 64'(exp_wr[i]));
        check({nm, "/done"}, 64'(bus.load_done_o), 64'(ed));
        check({nm, "/err"}, 64'(bus.load_err_o), 64'(ee));
        check({nm, "/core_rst_n"}, 64'(bus.core_rst_n_o), 64'(ed));
        if (ed && exp_wr.size() > 0 && we_cyc.size() == exp_wr.size())
            check({nm, "/done_lat"}, 64'(done_cyc - we_cyc[$]), 64'd1);
        if (ed && exp_wr.size() == 0 && bv_cyc.size() >= 4)
            check({nm, "/done_lat0"}, 64'(done_cyc - bv_cyc[3]), 64'd2);
    endtask
    initial begin
        vecs[0]  = '{32'd2,    2, -1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{32'd0,    0, -1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'd4097, 0, -1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'd1,    2,  5, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'd3,    3, -1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'd1,    1, -1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{32'd2,    0,  2, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{32'd2,    4, -1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{32'd4096, 0, -1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'd0,    2, -1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'd1,    1,  7, 1'b0, 1'b0, 1'b1};
        for (int v = 0; v < 11; v++) begin
            do_reset($sformatf("vec%0d", v));
            make_image(vecs[v].n, vecs[v].nw, vecs[v].fixed);
            model(vecs[v].bad);
            send_all(vecs[v].bad);
            verify($sformatf("vec%0d", v), vecs[v].ed, vecs[v].ee);
        end
        for (int r = 0; r < 4; r++) begin
            int n, nw, bad;
            n = $urandom_range(1, 3);
            nw = n + $urandom_range(0, 1);
            bad = $urandom_range(0, 2) == 0 ? $urandom_range(0, 3 + 4 * nw) : -1;
            do_reset($sformatf("rnd%0d", r));
            make_image(32'(n), nw, 1'b0);
            model(bad);
            send_all(bad);
            verify($sformatf("rnd%0d", r), exp_done, exp_err);
        end
        do_reset("midrst");
        make_image(32'd3, 3, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(tx[i], 1'b1);
        repeat (40) @(negedge clk);
        check("midrst/nwrites", 64'(got_wr.size()), 64'd1);
        if (got_wr.size() > 0) check("midrst/write0", 64'(got_wr[0]), 64'({12'd0, tx[7], tx[6], tx[5], tx[4]}));
        check("midrst/done", 64'(bus.load_done_o), 64'd0);
        do_reset("midrst2");
        make_image(32'd1, 1, 1'b0);
        model(-1);
        send_all(-1);
        verify("reload", 1'b1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
